// File: rtl/comp_pkg.sv
// Shared types and constants for the graph-compute pipe stage.
package comp_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        PROCESS_EDGE = 2'd0,
        REDUCE       = 2'd1,
        APPLY        = 2'd2,
        OP_RSVD      = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        BFS      = 2'd0,
        CC       = 2'd1,
        SSSP     = 2'd2,
        ALG_RSVD = 2'd3
    } alg_e;

endpackage

// File: rtl/comp_fifo.sv
// Result buffer for comp_pipe: stores {flag, data}; head reads as zero when empty.
module comp_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full & ~rst;
    assign pop_ok  = pop & ~empty & ~rst;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/comp_pipe.sv
// Graph-algorithm compute stage with a small in-order result buffer.
// Optional performance counters are enabled by defining COMP_PERF_CNT_EN.
module comp_pipe
    import comp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [1:0]            op_i,
    input  logic [1:0]            alg_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  flag_o,
    input  logic                  ready_i
`ifdef COMP_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      acc_cnt_o,
    output logic [CNT_W-1:0]      flag_cnt_o,
    output logic [CNT_W-1:0]      stall_cnt_o
`endif
);

    op_e                   op;
    alg_e                  alg;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_flag;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;

    assign op  = op_e'(op_i);
    assign alg = alg_e'(alg_i);

    // Reserved op/alg codes fall through to the pass-through default.
    always_comb begin
        res_data = data_a;
        res_flag = 1'b0;
        case (op)
            PROCESS_EDGE: begin
                if (alg == SSSP) res_data = data_a + data_b;
            end
            REDUCE: begin
                if (alg == BFS)
                    res_data = data_b;
                else if (alg == CC || alg == SSSP)
                    res_data = (data_a < data_b) ? data_a : data_b;
            end
            APPLY: begin
                if (alg == BFS) begin
                    res_flag = (data_a != data_b);
                end else if (alg == CC || alg == SSSP) begin
                    res_flag = (data_b < data_a);
                    res_data = res_flag ? data_a : data_b;
                end
            end
            default: ;
        endcase
    end

    assign ready_o = ~full;
    assign valid_o = ~empty;
    assign push    = valid_i & ready_o & ~rst;
    assign pop     = valid_o & ready_i;

    comp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({res_flag, res_data}),
        .full  (full),
        .empty (empty),
        .head  ({flag_o, data_o})
    );

`ifdef COMP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_o   <= '0;
            flag_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            acc_cnt_o   <= acc_cnt_o + CNT_W'(push);
            flag_cnt_o  <= flag_cnt_o + CNT_W'(push & (op == APPLY) & res_flag);
            stall_cnt_o <= stall_cnt_o + CNT_W'(valid_o & ~ready_i);
        end
    end
`endif

endmodule

// File: tb/tb_comp_pipe.sv
// Directed plus random bench for comp_pipe against a queue-based reference model.
module tb_comp_pipe;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic          flag;
        logic [DW-1:0] data;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_a, data_b;
    logic [1:0]    op_i, alg_i;
    logic          valid_i, ready_i;
    logic          ready_o, valid_o, flag_o;
    logic [DW-1:0] data_o;
`ifdef COMP_PERF_CNT_EN
    logic [31:0]   acc_cnt_o, flag_cnt_o, stall_cnt_o;
    logic [31:0]   m_acc, m_flag, m_stall;
`endif

    res_t          q[$];
    logic [DW-1:0] obs[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            obs_pops = 0;
    bit            last_push;

    always #5 clk = ~clk;

    comp_pipe #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_a  (data_a),
        .data_b  (data_b),
        .op_i    (op_i),
        .alg_i   (alg_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .flag_o  (flag_o),
        .ready_i (ready_i)
`ifdef COMP_PERF_CNT_EN
        ,
        .acc_cnt_o   (acc_cnt_o),
        .flag_cnt_o  (flag_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    function automatic res_t ref_compute(int op, int alg, logic [DW-1:0] a, logic [DW-1:0] b);
        res_t r;
        r.flag = 1'b0;
        r.data = a;
        if (op == 0) begin
            if (alg == 2) r.data = a + b;
        end else if (op == 1) begin
            if (alg == 0) r.data = b;
            else if (alg == 1 || alg == 2) r.data = (a < b) ? a : b;
        end else if (op == 2) begin
            if (alg == 0) r.flag = (a != b);
            else if (alg == 1 || alg == 2) begin
                r.flag = (b < a);
                r.data = r.flag ? a : b;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: compare outputs with the model at negedge, advance the model, return at posedge+1.
    task automatic step();
        bit   exp_valid, do_pop, do_push;
        res_t r;
        @(negedge clk);
        exp_valid = (q.size() != 0);
        check("valid_o", valid_o, exp_valid);
        check("ready_o", ready_o, q.size() < DEPTH);
        check("data_o", data_o, exp_valid ? q[0].data : '0);
        check("flag_o", flag_o, exp_valid ? q[0].flag : 1'b0);
`ifdef COMP_PERF_CNT_EN
        check("acc_cnt", acc_cnt_o, m_acc);
        check("flag_cnt", flag_cnt_o, m_flag);
        check("stall_cnt", stall_cnt_o, m_stall);
`endif
        if (valid_o && ready_i) begin
            obs.push_back(data_o);
            obs_pops++;
        end
        if (rst) begin
            q.delete();
            last_push = 0;
`ifdef COMP_PERF_CNT_EN
            m_acc = 0; m_flag = 0; m_stall = 0;
`endif
        end else begin
            do_pop  = exp_valid && ready_i;
            do_push = valid_i && (q.size() < DEPTH);
            r = ref_compute(int'(op_i), int'(alg_i), data_a, data_b);
            last_push = do_push;
`ifdef COMP_PERF_CNT_EN
            if (do_push) m_acc++;
            if (do_push && op_i == 2'd2 && r.flag) m_flag++;
            if (exp_valid && !ready_i) m_stall++;
`endif
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        if ($urandom_range(0, 1) == 0) return DW'($urandom_range(0, 7));
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; valid_i = 0; ready_i = 0;
        data_a = '0; data_b = '0; op_i = 0; alg_i = 0;
`ifdef COMP_PERF_CNT_EN
        m_acc = 0; m_flag = 0; m_stall = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // SSSP edge relaxation wraps modulo 2^64
        op_i = 2'd0; alg_i = 2'd2; data_a = '1; data_b = 64'd2; valid_i = 1;
        step();
        valid_i = 0;
        check("sssp_wrap_valid", valid_o, 1'b1);
        check("sssp_wrap_data", data_o, 64'd1);
        check("sssp_wrap_flag", flag_o, 1'b0);
        ready_i = 1;
        step();

        // APPLY cases
        valid_i = 1; op_i = 2'd2; alg_i = 2'd1; data_a = 64'd7; data_b = 64'd3;
        step();
        check("cc_apply1_data", data_o, 64'd7);
        check("cc_apply1_flag", flag_o, 1'b1);
        data_a = 64'd3; data_b = 64'd7;
        step();
        check("cc_apply2_data", data_o, 64'd7);
        check("cc_apply2_flag", flag_o, 1'b0);
        alg_i = 2'd0; data_a = 64'd5; data_b = 64'd5;
        step();
        check("bfs_apply_data", data_o, 64'd5);
        check("bfs_apply_flag", flag_o, 1'b0);
        valid_i = 0;
        step();

        // Fill to DEPTH with no consumer, hold the fifth, then drain in order
        ready_i = 0; obs.delete(); op_i = 2'd1; alg_i = 2'd2; data_b = 64'd20;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1; data_a = 64'(10 + i);
            step();
        end
        check("full_ready", ready_o, 1'b0);
        data_a = 64'd14;
        step();
        step();
        ready_i = 1;
        for (int k = 0; k < 10 && !last_push; k++) step();
        check("fifth_accepted", last_push, 1'b1);
        valid_i = 0;
        for (int k = 0; k < 10 && q.size() != 0; k++) step();
        step();
        check("drain_count", obs.size(), 5);
        for (int i = 0; i < 5; i++) begin
            logic [DW-1:0] got;
            got = (i < obs.size()) ? obs[i] : 'x;
            check("drain_order", got, 64'(10 + i));
        end

        // Reset with three results buffered; the concurrent valid_i must be dropped
        ready_i = 0; op_i = 2'd0; alg_i = 2'd1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1; data_a = rnd_data(); data_b = rnd_data();
            step();
        end
        rst = 1;
        step();
        rst = 0; valid_i = 0;
        check("rst_valid", valid_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        check("rst_data", data_o, '0);
`ifdef COMP_PERF_CNT_EN
        check("rst_acc", acc_cnt_o, '0);
        check("rst_stall", stall_cnt_o, '0);
`endif
        step();

        // 100-transaction stream
        ready_i = 1; obs_pops = 0;
        for (int i = 0; i < 100; i++) begin
            valid_i = 1;
            op_i = 2'($urandom_range(0, 3)); alg_i = 2'($urandom_range(0, 3));
            data_a = rnd_data(); data_b = rnd_data();
            step();
        end
        valid_i = 0;
        step();
        check("stream_count", obs_pops, 100);

        // Counter scenario: 10 flagged CC applies, then 6 stalled cycles
        rst = 1;
        step();
        rst = 0; ready_i = 1; op_i = 2'd2; alg_i = 2'd1;
        for (int i = 0; i < 10; i++) begin
            valid_i = 1; data_a = 64'(100 + i); data_b = 64'(i);
            step();
        end
        valid_i = 0; ready_i = 0;
        repeat (6) step();
`ifdef COMP_PERF_CNT_EN
        check("cnt_acc", acc_cnt_o, 64'd10);
        check("cnt_flag", flag_cnt_o, 64'd10);
        check("cnt_stall", stall_cnt_o, 64'd6);
`endif
        ready_i = 1;
        step();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            op_i    = 2'($urandom_range(0, 3));
            alg_i   = 2'($urandom_range(0, 3));
            data_a  = rnd_data();
            data_b  = rnd_data();
            step();
        end
        rst = 0; valid_i = 0; ready_i = 1;
        repeat (DEPTH + 1) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
